// File: rtl/pk_report_pkg.sv
// Shared layout of the 256-bit peak report and the 10-word host frame built from it.
package pk_report_pkg;

    localparam int unsigned PK_REPORT_WIDTH = 256;
    localparam int unsigned PK_WORD_WIDTH   = 32;

    localparam int unsigned PK_NUM_I_LSB = 224;
    localparam int unsigned PK_NUM_Q_LSB = 192;
    localparam int unsigned PK_VAL_I_LSB = 128;
    localparam int unsigned PK_VAL_Q_LSB = 64;
    localparam int unsigned PK_RES_I_LSB = 32;
    localparam int unsigned PK_RES_Q_LSB = 0;

    localparam logic [PK_WORD_WIDTH-1:0] PK_HEADER_WORD = 32'h504b504b;
    localparam int unsigned PK_FRAME_WORDS = 10;
    localparam int unsigned PK_WIDX_WIDTH  = 4;

    typedef logic [PK_WIDX_WIDTH-1:0] pk_widx_t;

    localparam pk_widx_t PK_LAST_WIDX = pk_widx_t'(PK_FRAME_WORDS - 1);

    typedef struct packed {
        logic [31:0] peak_num_i;
        logic [31:0] peak_num_q;
        logic [63:0] peak_val_i;
        logic [63:0] peak_val_q;
        logic [31:0] peak_result_i;
        logic [31:0] peak_result_q;
    } pk_report_t;

    // Frame word w of a report; 64-bit values go out high half first.
    function automatic logic [PK_WORD_WIDTH-1:0] pk_frame_word(
        input pk_report_t                 rpt,
        input pk_widx_t                   w,
        input logic [PK_WORD_WIDTH-1:0]   seq,
        input logic [PK_WORD_WIDTH-1:0]   hdr
    );
        logic [PK_WORD_WIDTH-1:0] word;
        case (w)
            4'd0:    word = hdr;
            4'd1:    word = seq;
            4'd2:    word = rpt.peak_num_i;
            4'd3:    word = rpt.peak_num_q;
            4'd4:    word = rpt.peak_val_i[63:32];
            4'd5:    word = rpt.peak_val_i[31:0];
            4'd6:    word = rpt.peak_val_q[63:32];
            4'd7:    word = rpt.peak_val_q[31:0];
            4'd8:    word = rpt.peak_result_i;
            default: word = rpt.peak_result_q;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/pk_report_serializer.sv
// Serializes one 256-bit peak-report beat into a 10-word 32-bit AXI-Stream frame
// (header, sequence number, report fields); one-report holding buffer.
module pk_report_serializer
    import pk_report_pkg::*;
#(
    parameter int unsigned                PK_AXI_DATA_WIDTH = 256,
    parameter int unsigned                OUT_DATA_WIDTH    = 32,
    parameter logic [OUT_DATA_WIDTH-1:0]  HEADER_WORD       = PK_HEADER_WORD
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [PK_AXI_DATA_WIDTH-1:0]  s_pk_axis_tdata,
    input  logic                          s_pk_axis_tvalid,
    input  logic                          s_pk_axis_tlast,
    output logic                          s_pk_axis_tready,
    output logic [OUT_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic                          report_enable,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   drop_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                state_q, state_d;
    pk_widx_t                  w_q, w_d, w_inc;
    pk_report_t                hold_q, hold_d;
    logic [OUT_DATA_WIDTH-1:0] tdata_d;
    logic                      tvalid_d, tlast_d;
    logic [31:0]               frame_count_d, drop_count_d;
    logic                      beat_acc, out_hs, last_hs;
    logic                      unused_tlast;

    // Every beat is a whole report, so the input tlast carries no information.
    assign unused_tlast = s_pk_axis_tlast;

    assign out_hs   = (state_q == ST_SEND) & m_axis_tready;
    assign last_hs  = out_hs & (w_q == PK_LAST_WIDX);
    assign w_inc    = w_q + pk_widx_t'(1);

    // Buffer refills only when empty or in the very cycle its last word leaves.
    assign s_pk_axis_tready = aresetn & ((state_q == ST_IDLE) | last_hs);
    assign beat_acc         = s_pk_axis_tvalid & s_pk_axis_tready;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        hold_d        = hold_q;
        tdata_d       = m_axis_tdata;
        tvalid_d      = m_axis_tvalid;
        tlast_d       = m_axis_tlast;
        frame_count_d = frame_count;
        drop_count_d  = drop_count;

        if (out_hs) begin
            if (last_hs) begin
                state_d       = ST_IDLE;
                w_d           = '0;
                tvalid_d      = 1'b0;
                tlast_d       = 1'b0;
                frame_count_d = 32'(frame_count + 32'd1);
            end else begin
                w_d     = w_inc;
                tdata_d = pk_frame_word(hold_q, w_inc, frame_count, HEADER_WORD);
                tlast_d = (w_inc == PK_LAST_WIDX);
            end
        end

        if (beat_acc) begin
            if (report_enable) begin
                hold_d   = pk_report_t'(s_pk_axis_tdata);
                state_d  = ST_SEND;
                w_d      = '0;
                tdata_d  = HEADER_WORD;
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
            end else if (drop_count != 32'hFFFF_FFFF) begin
                drop_count_d = 32'(drop_count + 32'd1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            w_q           <= '0;
            hold_q        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= '0;
            drop_count    <= '0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            hold_q        <= hold_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            frame_count   <= frame_count_d;
            drop_count    <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_pk_report_serializer.sv
// Bench for pk_report_serializer: directed scenarios plus random traffic against a frame-queue model.
module tb_pk_report_serializer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [255:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic         report_enable;
    logic [31:0]  frame_count;
    logic [31:0]  drop_count;

    always #5 aclk = ~aclk;

    pk_report_serializer dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_pk_axis_tdata  (s_tdata),
        .s_pk_axis_tvalid (s_tvalid),
        .s_pk_axis_tlast  (s_tlast),
        .s_pk_axis_tready (s_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tready    (m_tready),
        .report_enable    (report_enable),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    logic        last_acc = 1'b0;
    logic        rst_prev = 1'b1;

    // Reference model: words still owed to the host, plus counters.
    logic [31:0] exp_q[$];
    logic [31:0] m_started = 0;
    logic [31:0] m_done    = 0;
    logic [31:0] m_drop    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_frame(input logic [255:0] d);
        exp_q.push_back(32'h504b504b);
        exp_q.push_back(m_started);
        exp_q.push_back(d[255:224]);
        exp_q.push_back(d[223:192]);
        exp_q.push_back(d[191:160]);
        exp_q.push_back(d[159:128]);
        exp_q.push_back(d[127:96]);
        exp_q.push_back(d[95:64]);
        exp_q.push_back(d[63:32]);
        exp_q.push_back(d[31:0]);
        m_started = m_started + 32'd1;
    endtask

    // One clock: pick m_tready, compare outputs with the model, advance the model.
    task automatic tick();
        logic exp_sr;
        logic acc;
        logic ohs;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_tready = 1'($urandom % 2);
        endcase
        #1;
        exp_sr = aresetn && ((exp_q.size() == 0) || (exp_q.size() == 1 && m_tready));
        chk("s_tready", 32'(s_tready), 32'(exp_sr));
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_tdata", m_tdata, exp_q[0]);
            chk("m_tlast", 32'(m_tlast), 32'(exp_q.size() == 1));
        end
        chk("frame_count", frame_count, m_done);
        chk("drop_count", drop_count, m_drop);
        if (rst_prev) begin
            chk("rst_tdata", m_tdata, 32'd0);
            chk("rst_tlast", 32'(m_tlast), 32'd0);
        end
        if (!aresetn) begin
            exp_q.delete();
            m_started = 0;
            m_done    = 0;
            m_drop    = 0;
            last_acc  = 1'b0;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            acc = s_tvalid && exp_sr;
            ohs = (exp_q.size() != 0) && m_tready;
            if (ohs) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = m_done + 32'd1;
            end
            if (acc) begin
                if (report_enable) push_frame(s_tdata);
                else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end
            last_acc = acc;
        end
        cyc++;
        @(negedge aclk);
    endtask

    task automatic send_beats(input int n, input logic en, input int mode,
                              input logic use_fix, input logic [255:0] fix);
        int acc_n = 0;
        int g = 0;
        rdy_mode      = mode;
        report_enable = en;
        s_tdata       = use_fix ? fix : rand256();
        s_tvalid      = 1'b1;
        while (acc_n < n && g < 40 * n + 40) begin
            tick();
            g++;
            if (last_acc) begin
                acc_n++;
                s_tdata = rand256();
            end
        end
        s_tvalid = 1'b0;
        chk("accept_budget", 32'(acc_n), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && g < 400) begin
            tick();
            g++;
        end
        chk("drain_budget", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [255:0] fixed;
        int g;
        aresetn       = 1'b0;
        s_tdata       = '0;
        s_tvalid      = 1'b0;
        s_tlast       = 1'b0;
        m_tready      = 1'b1;
        report_enable = 1'b1;
        @(negedge aclk);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Single known report.
        fixed = {32'd3, 32'd5, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 32'd100, 32'd200};
        send_beats(1, 1'b1, 0, 1'b1, fixed);
        drain();
        tick();
        chk("single_frame_count", frame_count, 32'd1);

        // Back-to-back, continuous tready.
        send_beats(3, 1'b1, 0, 1'b0, '0);
        drain();

        // Backpressure 1,0,0,1.
        send_beats(2, 1'b1, 1, 1'b0, '0);
        drain();

        // Disabled: beats dropped, then an enabled frame continues the sequence.
        send_beats(4, 1'b0, 0, 1'b0, '0);
        tick();
        send_beats(1, 1'b1, 0, 1'b0, '0);
        drain();

        // Reset while word 5 is on the bus.
        send_beats(1, 1'b1, 0, 1'b0, '0);
        g = 0;
        while (exp_q.size() > 5 && g < 50) begin
            tick();
            g++;
        end
        chk("reach_word5", 32'(exp_q.size()), 32'd5);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        send_beats(1, 1'b1, 0, 1'b0, '0);
        drain();

        // Sequence wrap.
        tick();
        force dut.frame_count = 32'hFFFF_FFFF;
        m_done    = 32'hFFFF_FFFF;
        m_started = 32'hFFFF_FFFF;
        tick();
        tick();
        release dut.frame_count;
        tick();
        send_beats(1, 1'b1, 0, 1'b0, '0);
        drain();
        tick();
        chk("wrap_frame_count", frame_count, 32'd0);

        // Random traffic.
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            s_tvalid      = 1'($urandom % 2);
            report_enable = (($urandom % 4) != 0);
            s_tdata       = rand256();
            tick();
        end
        rdy_mode = 0;
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
